// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna core's instruction and data ports onto one shared memory port.
// Data has priority; a streak limit keeps fetches from starving; a watchdog aborts dead transactions.
module vigna_bus_arbiter #(
    parameter int          MAX_D_BURST = 4,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        m_src,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  MAX_STREAK = 4'(MAX_D_BURST);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_streak, w_streak_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic        r_m_valid, w_m_valid_next;
    logic [31:0] r_m_addr, w_m_addr_next;
    logic [31:0] r_m_wdata, w_m_wdata_next;
    logic [3:0]  r_m_wstrb, w_m_wstrb_next;
    logic        r_m_src, w_m_src_next;
    logic        r_i_ready, w_i_ready_next;
    logic        r_d_ready, w_d_ready_next;
    logic [31:0] r_i_rdata, w_i_rdata_next;
    logic [31:0] r_d_rdata, w_d_rdata_next;
    logic        r_bus_err, w_bus_err_next;
    logic        w_grant_d;
    logic        w_timeout;
    logic        w_finish;
    logic [31:0] w_resp_data;

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_streak_next  = r_streak;
        w_cnt_next     = r_cnt;
        w_m_valid_next = r_m_valid;
        w_m_addr_next  = r_m_addr;
        w_m_wdata_next = r_m_wdata;
        w_m_wstrb_next = r_m_wstrb;
        w_m_src_next   = r_m_src;
        w_i_ready_next = 1'b0;
        w_d_ready_next = 1'b0;
        w_i_rdata_next = r_i_rdata;
        w_d_rdata_next = r_d_rdata;
        w_bus_err_next = 1'b0;
        w_grant_d      = 1'b0;
        w_finish       = 1'b0;
        w_resp_data    = m_rdata;

        case (r_state)
            ST_IDLE: begin
                if (d_valid || i_valid) begin
                    w_grant_d = d_valid && !(i_valid && (r_streak == MAX_STREAK));
                    if (w_grant_d) begin
                        w_m_addr_next  = d_addr;
                        w_m_wdata_next = d_wdata;
                        w_m_wstrb_next = d_wstrb;
                        w_m_src_next   = 1'b1;
                        if (!i_valid)
                            w_streak_next = 4'd0;
                        else if (r_streak != 4'hF)
                            w_streak_next = r_streak + 4'd1;
                    end else begin
                        w_m_addr_next  = i_addr;
                        w_m_wdata_next = 32'd0;
                        w_m_wstrb_next = 4'd0;
                        w_m_src_next   = 1'b0;
                        w_streak_next  = 4'd0;
                    end
                    w_m_valid_next = 1'b1;
                    w_cnt_next     = 16'd0;
                    w_state_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // m_ready takes precedence over a simultaneous timeout
                if (m_ready) begin
                    w_finish = 1'b1;
                end else if (w_timeout) begin
                    w_finish       = 1'b1;
                    w_resp_data    = ERR_DATA;
                    w_bus_err_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
                if (w_finish) begin
                    w_m_valid_next = 1'b0;
                    w_state_next   = ST_RESP;
                    if (r_m_src) begin
                        w_d_rdata_next = w_resp_data;
                        w_d_ready_next = 1'b1;
                    end else begin
                        w_i_rdata_next = w_resp_data;
                        w_i_ready_next = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_streak  <= 4'd0;
            r_cnt     <= 16'd0;
            r_m_valid <= 1'b0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
            r_m_wstrb <= 4'd0;
            r_m_src   <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_streak  <= w_streak_next;
            r_cnt     <= w_cnt_next;
            r_m_valid <= w_m_valid_next;
            r_m_addr  <= w_m_addr_next;
            r_m_wdata <= w_m_wdata_next;
            r_m_wstrb <= w_m_wstrb_next;
            r_m_src   <= w_m_src_next;
            r_i_ready <= w_i_ready_next;
            r_d_ready <= w_d_ready_next;
            r_i_rdata <= w_i_rdata_next;
            r_d_rdata <= w_d_rdata_next;
            r_bus_err <= w_bus_err_next;
        end
    end

    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;
    assign m_src   = r_m_src;
    assign i_ready = r_i_ready;
    assign d_ready = r_d_ready;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: fetch, load, store, contention, timeout and reset cases.
module tb_vigna_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_src;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    vigna_bus_arbiter #(
        .MAX_D_BURST(4),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .i_valid(i_valid),
        .i_addr (i_addr),
        .i_ready(i_ready),
        .i_rdata(i_rdata),
        .d_valid(d_valid),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_wstrb(d_wstrb),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata),
        .m_src  (m_src),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] acc;
        acc = {22'd0, m_valid, m_src, i_ready, d_ready, bus_err, m_wstrb, 1'b0} |
              m_addr | m_wdata | i_rdata | d_rdata;
        chk(tag, acc, 32'd0);
    endtask

    logic exp_src [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int cnt;
        resetn  = 1'b0;
        i_valid = 1'b0; i_addr = 32'd0;
        d_valid = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
        m_ready = 1'b0; m_rdata = 32'd0;
        tick(); tick();
        chk_all_zero("reset_outputs");
        resetn = 1'b1;
        tick();

        // single zero-wait fetch
        i_valid = 1'b1; i_addr = 32'h0;
        tick();
        chk("fetch_m_valid", m_valid, 1);
        chk("fetch_m_src", m_src, 0);
        chk("fetch_m_wstrb", m_wstrb, 0);
        m_ready = 1'b1; m_rdata = 32'h0000_2087;
        tick();
        m_ready = 1'b0;
        chk("fetch_i_ready", i_ready, 1);
        chk("fetch_i_rdata", i_rdata, 32'h0000_2087);
        chk("fetch_d_ready", d_ready, 0);
        chk("fetch_m_valid_low", m_valid, 0);
        i_valid = 1'b0;
        tick();
        chk("fetch_i_ready_once", i_ready, 0);

        // load with three wait cycles
        d_valid = 1'b1; d_addr = 32'h4; d_wstrb = 4'd0;
        tick();
        chk("load_m_src", m_src, 1);
        chk("load_m_addr", m_addr, 32'h4);
        chk("load_m_wstrb", m_wstrb, 0);
        tick(); tick(); tick();
        chk("load_wait_d_ready", d_ready, 0);
        chk("load_wait_m_valid", m_valid, 1);
        m_ready = 1'b1; m_rdata = 32'h4000_0000;
        tick();
        m_ready = 1'b0;
        chk("load_d_ready", d_ready, 1);
        chk("load_d_rdata", d_rdata, 32'h4000_0000);
        chk("load_i_rdata_held", i_rdata, 32'h0000_2087);
        d_valid = 1'b0;
        tick();
        chk("load_d_ready_once", d_ready, 0);

        // store; upstream changes during BUSY must not leak through
        d_valid = 1'b1; d_addr = 32'h8; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
        tick();
        d_wdata = 32'hFFFF_0000; d_wstrb = 4'b1111; d_addr = 32'hC;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("store_m_wstrb_%0d", k), m_wstrb, 4'b0011);
            chk($sformatf("store_m_wdata_%0d", k), m_wdata, 32'h1234_5678);
            tick();
        end
        m_ready = 1'b1; m_rdata = 32'h0;
        tick();
        m_ready = 1'b0;
        chk("store_d_ready", d_ready, 1);
        d_valid = 1'b0;
        tick();
        chk("store_d_ready_once", d_ready, 0);

        // contention: both masters request continuously
        i_valid = 1'b1; i_addr = 32'h100;
        d_valid = 1'b1; d_addr = 32'h200; d_wstrb = 4'd0;
        for (int g = 0; g < 10; g++) begin
            cnt = 0;
            while (!m_valid && cnt < 10) begin
                tick();
                cnt++;
            end
            if (!m_valid) begin
                chk($sformatf("grant_%0d_wait", g), 32'd0, 32'd1);
                break;
            end
            chk($sformatf("grant_%0d_src", g), m_src, exp_src[g]);
            m_ready = 1'b1; m_rdata = 32'hA000_0000 + g;
            tick();
            m_ready = 1'b0;
            if (exp_src[g])
                chk($sformatf("grant_%0d_d_rdata", g), d_rdata, 32'hA000_0000 + g);
            else
                chk($sformatf("grant_%0d_i_rdata", g), i_rdata, 32'hA000_0000 + g);
            if (g == 9) begin
                i_valid = 1'b0;
                d_valid = 1'b0;
            end
            tick();
        end
        tick();
        chk("contention_idle", m_valid, 0);

        // watchdog: memory never answers
        d_valid = 1'b1; d_addr = 32'hC; d_wstrb = 4'd0;
        tick();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!m_valid) break;
            cnt++;
            tick();
        end
        chk("timeout_busy_cycles", cnt, 8);
        chk("timeout_d_ready", d_ready, 1);
        chk("timeout_bus_err", bus_err, 1);
        chk("timeout_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_valid = 1'b0;
        tick();
        chk("timeout_bus_err_once", bus_err, 0);
        tick();
        chk("timeout_back_idle", m_valid, 0);

        // m_ready on the last watchdog cycle wins: no error
        d_valid = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("edge_still_busy", m_valid, 1);
        m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
        tick();
        m_ready = 1'b0;
        chk("edge_d_ready", d_ready, 1);
        chk("edge_bus_err", bus_err, 0);
        chk("edge_d_rdata", d_rdata, 32'h5555_AAAA);
        d_valid = 1'b0;
        tick(); tick();

        // reset in the middle of a fetch
        i_valid = 1'b1; i_addr = 32'h20;
        tick();
        chk("rst_pre_busy", m_valid, 1);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_async_clear");
        tick();
        resetn = 1'b1;
        chk("rst_no_stale_ready", i_ready, 0);
        tick();
        chk("rst_refetch_m_valid", m_valid, 1);
        chk("rst_refetch_m_addr", m_addr, 32'h20);
        m_ready = 1'b1; m_rdata = 32'h0000_ABCD;
        tick();
        m_ready = 1'b0;
        chk("rst_refetch_i_ready", i_ready, 1);
        chk("rst_refetch_i_rdata", i_rdata, 32'h0000_ABCD);
        i_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/vigna_bus_arbiter.md
Name: vigna_bus_arbiter

Overview:
- Merges the vigna core's instruction port (i_*) and data port (d_*) onto one shared memory port (m_*).
- Sits directly downstream of the core, between the core and a single-ported unified memory.
- Arbitration is fixed priority with data first, plus a starvation guard for instruction fetch.
- A bus-timeout watchdog returns an error response when memory never answers.

Parameters:
- MAX_D_BURST, 4: consecutive data grants allowed while i_valid is pending before instruction is forced (1..15).
- TIMEOUT, 64: cycles to wait for m_ready before aborting (0 disables the watchdog; max 65535).
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on a timed-out transaction.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_valid  in  1  instruction read request; held until i_ready.
- i_addr  in  32  instruction address.
- i_ready  out  1  one-cycle response pulse; i_rdata valid in the same cycle.
- i_rdata  out  32  instruction word.
- d_valid  in  1  data request; held until d_ready.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte strobes; 0 means read.
- d_ready  out  1  one-cycle response pulse.
- d_rdata  out  32  load data.
- m_valid  out  1  memory request.
- m_ready  in  1  memory completion; m_rdata valid in the same cycle.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_wstrb  out  4  memory byte strobes.
- m_rdata  in  32  memory read data.
- m_src  out  1  owner of the current transaction (0 = instruction, 1 = data).
- bus_err  out  1  one-cycle pulse coincident with the ready of a timed-out transaction.

Behaviour:
- Reset: asynchronous, active-low. Clears the following:
  - all outputs to 0: m_valid, m_addr, m_wdata, m_wstrb, m_src, i_ready, d_ready, i_rdata, d_rdata, bus_err;
  - state to IDLE;
  - d_streak and the timeout counter to 0.
  - Reset mid-transaction abandons the transaction; no response is issued.
- States:
  - IDLE: sample requests and issue a grant.
  - BUSY: m_valid held high.
  - RESP: upstream ready pulse.
- IDLE transitions:
  - No request: stay in IDLE.
  - Otherwise: latch address, data and strobes from the winner into the m_* registers, set m_src, go to BUSY. m_valid=1 from the next cycle.
- Grant rule:
  - d_valid only: grant data.
  - i_valid only: grant instruction.
  - Both asserted: grant data unless d_streak == MAX_D_BURST, in which case grant instruction.
- d_streak update:
  - increments (saturating) on a data grant made while i_valid=1;
  - resets to 0 on any instruction grant;
  - resets to 0 on a data grant made while i_valid=0.
- Instruction grants drive m_wstrb=0 and m_wdata=0.
- m_* outputs are stable for the whole BUSY state, regardless of upstream input changes.
- BUSY transitions:
  - On m_ready=1: capture m_rdata into the owner's rdata register, drop m_valid, go to RESP.
  - Timeout (TIMEOUT != 0): counter runs from 0 in the first BUSY cycle. If it reaches TIMEOUT-1 without m_ready, drop m_valid, load ERR_DATA into the owner's rdata, set bus_err, go to RESP.
  - If m_ready and the timeout occur in the same cycle, m_ready wins and there is no error.
- RESP:
  - Owner's ready=1 for exactly one cycle; bus_err as determined in BUSY; then go to IDLE.
  - Requests are not sampled in RESP. The master still holds its old valid during this cycle, so a new grant is possible no earlier than the cycle after RESP.
- rdata registers hold their value until the next response to the same port.
- Write responses also capture m_rdata into d_rdata; the contents are don't-care to the core.
- Latency: request seen in IDLE in cycle 0 → m_valid in cycle 1. With m_ready in cycle k (k≥1), upstream ready is in cycle k+1.
  - Zero-wait memory: 2 cycles request-to-ready, 3-cycle throughput per transaction.
- A master dropping valid while its request is in BUSY is a protocol violation. The transaction completes anyway and the ready pulse is still issued.

Test Plan:
- Single fetch: i_valid, i_addr=0x0, memory answers 0x00002087 with 0 wait → m_valid cycle 1, i_ready=1 with i_rdata=0x00002087 cycle 2, d_ready never high.
- Load: d_valid, d_addr=0x4, d_wstrb=0, memory returns 0x40000000 after 3 wait cycles → m_src=1, m_wstrb=0, d_rdata=0x40000000 with d_ready exactly one cycle after m_ready.
- Store: d_wstrb=4'b0011, d_wdata=0x12345678 → m_wstrb=0011 and m_wdata=0x12345678 stable throughout BUSY, one d_ready pulse.
- Contention: i_valid held continuously, data re-requests immediately after each d_ready, MAX_D_BURST=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT=8, memory never raises m_ready → m_valid high 8 cycles then low; d_ready=1, bus_err=1, d_rdata=0xDEADBEEF in one cycle; return to IDLE.
- Reset mid-BUSY: drop resetn during a fetch → all outputs 0 immediately; after release, a fresh fetch completes normally with no stale ready pulse.
